// File: rtl/axil_pkg.sv
// axil_pkg: shared types and constants for the AXI4-Lite read master.
// Holds the FSM state enum, RRESP encodings and the default parameter values.
// Optional feature macro: AXIL_RD_TIMEOUT_EN adds the DRAIN state.
package axil_pkg;

  localparam int unsigned AXIL_ADDR_W_DEF      = 64;
  localparam int unsigned AXIL_DATA_W_DEF      = 64;
  localparam int unsigned AXIL_TIMEOUT_CYC_DEF = 256;
  localparam logic [2:0]  AXIL_PROT_DEF        = 3'b000;

  // Width of the read-data timeout counter
  localparam int unsigned TMR_W = 16;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_RESP  = 3'd3
`ifdef AXIL_RD_TIMEOUT_EN
    ,
    ST_DRAIN = 3'd4
`endif
  } state_e;

endpackage

// File: rtl/axil_rd_timer.sv
// axil_rd_timer: read-data timeout counter for axil_read_master.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   clr         restart count from zero (entry to DATA)
//   en          count this cycle (DATA without rvalid)
//   expired     count has reached TIMEOUT_CYC-1 while counting
module axil_rd_timer
  import axil_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = AXIL_TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMR_W-1:0] LAST_CNT = TMR_W'(TIMEOUT_CYC - 1);

  logic [TMR_W-1:0] r_cnt;

  // Cycle counter, restarted on every DATA entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + TMR_W'(1);
    end
  end

  // Qualified by en so a same-cycle rvalid always beats the timeout
  assign expired = en && (r_cnt == LAST_CNT);

endmodule

// File: rtl/axil_read_master.sv
// axil_read_master: single-outstanding AXI4-Lite read master.
// A request on req_* issues one AR beat, waits for the R beat and presents the
// captured data/response on rsp_* until consumed.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/ready/addr       request in
//   rsp_valid/ready/data/resp  response out, rsp_err = rsp_resp[1]
//   araddr/arvalid/arprot/arready, rdata/rresp/rvalid/rready  AXI4-Lite read
//   timeout_flag               sticky read-data timeout indicator
// Optional feature macro: AXIL_RD_TIMEOUT_EN enables the read-data timeout,
// the DRAIN state and the axil_rd_timer instance; otherwise DATA waits forever.
module axil_read_master
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_W      = AXIL_ADDR_W_DEF,
  parameter int unsigned DATA_W      = AXIL_DATA_W_DEF,
  parameter logic [2:0]  PROT        = AXIL_PROT_DEF,
  parameter int unsigned TIMEOUT_CYC = AXIL_TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_resp,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  output logic [2:0]        arprot,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic              timeout_flag
);

  state_e r_state;
  state_e w_state_nxt;
  logic   w_capture;
  logic   w_timeout;
  logic   w_accept;

  logic              r_req_ready;
  logic              r_arvalid;
  logic              r_rready;
  logic              r_rsp_valid;
  logic [ADDR_W-1:0] r_araddr;
  logic [DATA_W-1:0] r_rsp_data;
  logic [1:0]        r_rsp_resp;

  assign w_accept = (r_state == ST_IDLE) && req_valid;

`ifdef AXIL_RD_TIMEOUT_EN
  logic w_expired;
  logic r_to_pend;
  logic r_timeout_flag;

  axil_rd_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     ((r_state == ST_ADDR) && arready),
    .en      ((r_state == ST_DATA) && !rvalid),
    .expired (w_expired)
  );

  // r_to_pend routes the consumed timeout response into DRAIN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_to_pend      <= 1'b0;
      r_timeout_flag <= 1'b0;
    end else begin
      if (w_timeout) begin
        r_to_pend      <= 1'b1;
        r_timeout_flag <= 1'b1;
      end else if ((r_state == ST_RESP) && rsp_ready) begin
        r_to_pend <= 1'b0;
      end
    end
  end

  assign timeout_flag = r_timeout_flag;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^(32'(TIMEOUT_CYC));
  assign timeout_flag = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and capture strobes
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) w_state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        if (arready) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (rvalid) begin
          w_state_nxt = ST_RESP;
          w_capture   = 1'b1;
        end
`ifdef AXIL_RD_TIMEOUT_EN
        else if (w_expired) begin
          w_state_nxt = ST_RESP;
          w_timeout   = 1'b1;
        end
`endif
      end
      ST_RESP: begin
`ifdef AXIL_RD_TIMEOUT_EN
        if (rsp_ready) w_state_nxt = r_to_pend ? ST_DRAIN : ST_IDLE;
`else
        if (rsp_ready) w_state_nxt = ST_IDLE;
`endif
      end
`ifdef AXIL_RD_TIMEOUT_EN
      ST_DRAIN: begin
        // Swallow the late beat belonging to the timed-out read
        if (rvalid) w_state_nxt = ST_IDLE;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs, decoded from the next state so they align with r_state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req_ready <= 1'b1;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_araddr    <= '0;
      r_rsp_data  <= '0;
      r_rsp_resp  <= '0;
    end else begin
      r_req_ready <= (w_state_nxt == ST_IDLE);
      r_arvalid   <= (w_state_nxt == ST_ADDR);
`ifdef AXIL_RD_TIMEOUT_EN
      r_rready    <= (w_state_nxt == ST_DATA) || (w_state_nxt == ST_DRAIN);
`else
      r_rready    <= (w_state_nxt == ST_DATA);
`endif
      r_rsp_valid <= (w_state_nxt == ST_RESP);
      if (w_accept) begin
        r_araddr <= req_addr;
      end
      if (w_capture) begin
        r_rsp_data <= rdata;
        r_rsp_resp <= rresp;
      end else if (w_timeout) begin
        r_rsp_data <= '0;
        r_rsp_resp <= RESP_SLVERR;
      end
    end
  end

  assign req_ready = r_req_ready;
  assign arvalid   = r_arvalid;
  assign rready    = r_rready;
  assign rsp_valid = r_rsp_valid;
  assign araddr    = r_araddr;
  assign rsp_data  = r_rsp_data;
  assign rsp_resp  = r_rsp_resp;
  assign rsp_err   = r_rsp_resp[1];
  assign arprot    = PROT;

endmodule

// File: tb/tb_axil_read_master.sv
// Scoreboard bench for axil_read_master: directed reads push expected
// {resp,data} into a queue; a negedge monitor pops on every rsp handshake.
// Build with AXIL_RD_TIMEOUT_EN defined to exercise the timeout path.
module tb_axil_read_master;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_resp;
  logic              rsp_err;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic [2:0]        arprot;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic              timeout_flag;

  int n_vec = 0;
  int n_err = 0;
  logic [65:0] exp_q[$];
  logic [65:0] mon_e;

  axil_read_master #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .PROT        (3'b010),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_resp     (rsp_resp),
    .rsp_err      (rsp_err),
    .araddr       (araddr),
    .arvalid      (arvalid),
    .arprot       (arprot),
    .arready      (arready),
    .rdata        (rdata),
    .rresp        (rresp),
    .rvalid       (rvalid),
    .rready       (rready),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every consumed response must match the head of the queue
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rsp: got data 0x%0h resp %0b with nothing expected", rsp_data, rsp_resp);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_data", rsp_data, mon_e[63:0]);
        chk("rsp_resp", 64'(rsp_resp), 64'(mon_e[65:64]));
        chk("rsp_err", 64'(rsp_err), 64'(mon_e[65]));
      end
    end
  end

  // One complete read with programmable slave / consumer stalls
  task automatic do_read(input logic [63:0] addr, input logic [63:0] data,
                         input logic [1:0] resp, input int ar_wait,
                         input int r_wait, input int rsp_wait, input bit stray);
    exp_q.push_back({resp, data});
    chk("idle_req_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
    req_addr  = ~addr;
    for (int i = 0; i <= ar_wait; i++) begin
      chk("ar_valid", 64'(arvalid), 64'd1);
      chk("ar_addr", araddr, addr);
      chk("ar_req_ready", 64'(req_ready), 64'd0);
      chk("ar_rsp_valid", 64'(rsp_valid), 64'd0);
      arready = (i == ar_wait);
      tick();
    end
    arready = 1'b0;
    for (int i = 0; i <= r_wait; i++) begin
      chk("data_rready", 64'(rready), 64'd1);
      chk("data_arvalid", 64'(arvalid), 64'd0);
      chk("data_rsp_valid", 64'(rsp_valid), 64'd0);
      if (i == r_wait) begin
        rvalid = 1'b1;
        rdata  = data;
        rresp  = resp;
      end
      tick();
    end
    rvalid = 1'b0;
    rdata  = ~data;
    rresp  = 2'b00;
    for (int i = 0; i <= rsp_wait; i++) begin
      chk("resp_valid", 64'(rsp_valid), 64'd1);
      chk("resp_data_hold", rsp_data, data);
      chk("resp_rready", 64'(rready), 64'd0);
      chk("resp_req_ready", 64'(req_ready), 64'd0);
      rsp_ready = (i == rsp_wait);
      if (stray && i < rsp_wait) begin
        rvalid    = 1'b1;
        req_valid = 1'b1;
      end else begin
        rvalid    = 1'b0;
        req_valid = 1'b0;
      end
      tick();
    end
    rsp_ready = 1'b0;
    rvalid    = 1'b0;
    req_valid = 1'b0;
    chk("done_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("done_req_ready", 64'(req_ready), 64'd1);
    chk("done_arvalid", 64'(arvalid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    arready   = 1'b0;
    rdata     = '0;
    rresp     = 2'b00;
    rvalid    = 1'b0;
    repeat (3) tick();
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_timeout_flag", 64'(timeout_flag), 64'd0);
    chk("rst_araddr", araddr, 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_rsp_resp", 64'(rsp_resp), 64'd0);
    chk("arprot", 64'(arprot), 64'd2);
    rst_n = 1'b1;
    tick();

    // Zero-wait read: rsp_valid three cycles after acceptance
    do_read(64'h1000, 64'hDEADBEEF_CAFEF00D, 2'b00, 0, 0, 0, 1'b0);
    // arready held off five cycles
    do_read(64'h2000_0040, 64'h0123_4567_89AB_CDEF, 2'b00, 5, 0, 0, 1'b0);
    // DECERR, then a normal EXOKAY read
    do_read(64'hFFFF_0000_0000_0008, 64'h1111_2222_3333_4444, 2'b11, 0, 1, 0, 1'b0);
    do_read(64'h10, 64'hA5A5_5A5A_0F0F_F0F0, 2'b01, 0, 0, 0, 1'b0);
    // Consumer stalls four cycles with stray rvalid / req_valid
    do_read(64'h3000, 64'h5555_AAAA_1234_8765, 2'b10, 1, 2, 4, 1'b1);

`ifdef AXIL_RD_TIMEOUT_EN
    // rvalid on the threshold cycle wins over the timeout
    do_read(64'h4000, 64'h0BAD_F00D_0000_0001, 2'b00, 0, 7, 0, 1'b0);
    chk("thresh_no_timeout", 64'(timeout_flag), 64'd0);

    // No rvalid: timeout after 8 DATA cycles, then drain a late beat
    exp_q.push_back({2'b10, 64'h0});
    req_valid = 1'b1;
    req_addr  = 64'h5000;
    tick();
    req_valid = 1'b0;
    chk("to_arvalid", 64'(arvalid), 64'd1);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("to_wait_rready", 64'(rready), 64'd1);
      chk("to_wait_rsp_valid", 64'(rsp_valid), 64'd0);
      tick();
    end
    chk("to_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("to_flag", 64'(timeout_flag), 64'd1);
    chk("to_rready", 64'(rready), 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("drain_req_ready", 64'(req_ready), 64'd0);
    chk("drain_rready", 64'(rready), 64'd1);
    chk("drain_rsp_valid", 64'(rsp_valid), 64'd0);
    rvalid = 1'b1;
    rdata  = 64'h7777_7777_7777_7777;
    rresp  = 2'b00;
    tick();
    rvalid = 1'b0;
    chk("post_drain_req_ready", 64'(req_ready), 64'd1);
    chk("post_drain_rready", 64'(rready), 64'd0);
    chk("post_drain_rsp_valid", 64'(rsp_valid), 64'd0);
    do_read(64'h6000, 64'hCAFE_0000_BEEF_0001, 2'b01, 0, 0, 0, 1'b0);
    chk("to_flag_sticky", 64'(timeout_flag), 64'd1);
`endif

    // Reset while in DATA abandons the read
    req_valid = 1'b1;
    req_addr  = 64'h7000;
    tick();
    req_valid = 1'b0;
    arready   = 1'b1;
    tick();
    arready = 1'b0;
    chk("pre_rst_rready", 64'(rready), 64'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_arvalid", 64'(arvalid), 64'd0);
    chk("mid_rst_rready", 64'(rready), 64'd0);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_araddr", araddr, 64'd0);
    chk("mid_rst_rsp_data", rsp_data, 64'd0);
    chk("mid_rst_rsp_resp", 64'(rsp_resp), 64'd0);
    chk("mid_rst_timeout_flag", 64'(timeout_flag), 64'd0);
    rst_n     = 1'b1;
    rvalid    = 1'b1;
    rdata     = 64'h9999_8888_7777_6666;
    rsp_ready = 1'b1;
    tick();
    tick();
    chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("abort_rready", 64'(rready), 64'd0);
    chk("abort_req_ready", 64'(req_ready), 64'd1);
    rvalid    = 1'b0;
    rsp_ready = 1'b0;
    tick();

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axil_read_master.md
AXIL_READ_MASTER -- requirements
Module: axil_read_master

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 64, giving the request address and ARADDR width.
REQ-002 The block SHALL have parameter DATA_W, default 64, giving the RDATA and rsp_data width; legal values are 32 and 64.
REQ-003 The block SHALL have parameter PROT, default 3'b000, which is driven constantly on arprot.
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 256, the read-data timeout; the range is 1..65535, and it is used only under AXIL_RD_TIMEOUT_EN.
REQ-005 The block SHALL have the following ports, clock and reset first:
  clk  in  1  clock.
  rst_n  in  1  reset, synchronous, active-low.
  req_valid  in  1  read request.
  req_ready  out  1  request accepted when high together with req_valid.
  req_addr  in  ADDR_W  byte address of the request.
  rsp_valid  out  1  response available.
  rsp_ready  in  1  consumer accepts the response.
  rsp_data  out  DATA_W  captured RDATA.
  rsp_resp  out  2  captured RRESP, or 2'b10 on timeout.
  rsp_err  out  1  equals rsp_resp[1].
  araddr  out  ADDR_W  AXI read address.
  arvalid  out  1  AXI read-address valid.
  arprot  out  3  AXI protection bits.
  arready  in  1  AXI read-address ready.
  rdata  in  DATA_W  AXI read data.
  rresp  in  2  AXI read response.
  rvalid  in  1  AXI read-data valid.
  rready  out  1  AXI read-data ready.
  timeout_flag  out  1  sticky timeout indicator; tied to 0 without the macro.

Function
REQ-006 The block SHALL be a single-outstanding master with states IDLE, ADDR, DATA and RESP, plus DRAIN under the macro.
REQ-007 In IDLE, the block SHALL drive req_ready=1; on req_valid it SHALL latch req_addr into araddr and move to ADDR.
REQ-008 In ADDR, arvalid SHALL be 1 and araddr SHALL be stable, both held until arready; on arready the block SHALL move to DATA. arvalid SHALL NOT drop before arready.
REQ-009 In DATA, rready SHALL be 1; on rvalid the block SHALL register rdata and rresp into rsp_data and rsp_resp, then move to RESP.
REQ-010 In RESP, rsp_valid SHALL be 1 and rsp_data/rsp_resp SHALL be stable; on rsp_ready the block SHALL return to IDLE.
REQ-011 req_ready SHALL be 0 in every state except IDLE, and rready SHALL be 0 outside DATA/DRAIN.
REQ-012 With zero-wait handshakes, latency SHALL be: request accepted in cycle 0, arvalid in cycle 1, rready in cycle 2, rsp_valid in cycle 3; the minimum issue interval is 4 cycles.
REQ-013 Any rvalid seen outside DATA/DRAIN SHALL be ignored, with rready held at 0.
REQ-014 rsp_err SHALL equal rsp_resp[1], covering both SLVERR and DECERR.

Reset
REQ-015 While rst_n=0 at a clk edge, the state SHALL be IDLE, and arvalid, rready, rsp_valid and timeout_flag SHALL be 0.
REQ-016 While rst_n=0, araddr, rsp_data and rsp_resp SHALL be 0.
REQ-017 Reset asserted mid-transaction SHALL abandon that transaction, and no response SHALL be produced for it.

Configuration
REQ-018 With AXIL_RD_TIMEOUT_EN defined, a 16-bit counter SHALL clear on entry to DATA and increment each DATA cycle without rvalid.
REQ-019 With AXIL_RD_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYC-1 without rvalid, the block SHALL load rsp_data=0 and rsp_resp=2'b10, set timeout_flag, and go to RESP.
REQ-020 With AXIL_RD_TIMEOUT_EN defined, after a timeout response is consumed the block SHALL go to DRAIN.
REQ-021 In DRAIN, req_ready SHALL be 0 and rready SHALL be 1; the first rvalid beat SHALL be discarded and the block SHALL then return to IDLE.
REQ-022 timeout_flag SHALL clear only on reset.
REQ-023 rvalid arriving in the same cycle as the timeout threshold SHALL win: the data is captured normally and no timeout is reported.
REQ-024 Without AXIL_RD_TIMEOUT_EN, DATA SHALL wait indefinitely, DRAIN and the counter SHALL be absent, and timeout_flag SHALL be 0.

Structure
REQ-025 Package axil_pkg SHALL hold the state enum, the RRESP constants (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11) and the default parameter values.
REQ-026 The timeout counter SHALL be sub-module axil_rd_timer, with ports clk, rst_n, clr, en and expired; it is instantiated only under the macro.

Verification
REQ-027 Single read to 0x1000 with zero-wait slave returning 0xDEADBEEF_CAFEF00D and OKAY -> rsp_valid in cycle 3, matching data, rsp_err=0.
REQ-028 arready delayed 5 cycles -> arvalid and araddr held stable for all 6 cycles, req_ready=0 throughout, and the response is correct.
REQ-029 Slave returns rresp=2'b11 -> rsp_resp=2'b11 and rsp_err=1; the next request is then accepted normally.
REQ-030 rsp_ready held low 4 cycles -> rsp_valid and rsp_data stable, no new request accepted, and a stray rvalid is not acknowledged.
REQ-031 With the macro and TIMEOUT_CYC=8, rvalid never asserted -> rsp_resp=2'b10 after 8 DATA cycles and timeout_flag=1; a late rvalid is drained, then the next read completes.
REQ-032 rst_n pulsed low while in DATA -> all outputs return to reset values next cycle, and no rsp_valid appears for the aborted read.
